// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: mult/div op encoding, mult/div FSM states, negate helpers.
package mips_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6
  } md_op_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } md_state_t;

  localparam int MD_ITERS = 32;

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return ~x + 32'd1;
  endfunction

  function automatic logic [63:0] neg64(input logic [63:0] x);
    return ~x + 64'd1;
  endfunction

endpackage

// File: rtl/mult_div_unit.sv
// Iterative 32x32 mult/div owning HI/LO; 33 busy cycles from issue, done pulses as new HI/LO appear.
// No backpressure: start is ignored entirely while busy, the control path must stall on busy.
module mult_div_unit
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  md_state_t   state, state_nxt;
  md_op_t      op_e;
  logic [4:0]  iter;
  logic [63:0] acc, acc_nxt;
  logic [31:0] opnd;
  logic        is_div, sign_a, sign_b;

  logic        is_muldiv, signed_op, a_neg, b_neg;
  logic [31:0] a_mag, b_mag;
  logic [32:0] add_sum;
  logic        sub_ok;
  logic [31:0] sub_diff;

  assign op_e = md_op_t'(op);
  assign busy = (state != IDLE);

  always_comb begin
    is_muldiv = (op_e == MD_MULT) || (op_e == MD_MULTU) || (op_e == MD_DIV) || (op_e == MD_DIVU);
    signed_op = (op_e == MD_MULT) || (op_e == MD_DIV);
    a_neg     = signed_op & a[31];
    b_neg     = signed_op & b[31];
    // Unsigned 32-bit magnitude: |-2^31| = 0x80000000 still fits.
    a_mag     = a_neg ? neg32(a) : a;
    b_mag     = b_neg ? neg32(b) : b;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start && is_muldiv) state_nxt = RUN;
      RUN:     if (iter == 5'(MD_ITERS - 1)) state_nxt = FIX;
      FIX:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // acc = {partial product, multiplier} for multiply, {remainder, quotient} for divide.
  always_comb begin
    add_sum  = {1'b0, acc[63:32]} + {1'b0, opnd};
    sub_ok   = {acc[63:32], acc[31]} >= {1'b0, opnd};
    sub_diff = {acc[62:32], acc[31]} - opnd;
    acc_nxt  = acc;
    if (is_div)
      acc_nxt = sub_ok ? {sub_diff, acc[30:0], 1'b1} : {acc[62:0], 1'b0};
    else
      acc_nxt = acc[0] ? {add_sum, acc[31:1]} : {1'b0, acc[63:32], acc[31:1]};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      iter   <= '0;
      acc    <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      sign_a <= 1'b0;
      sign_b <= 1'b0;
      hi     <= '0;
      lo     <= '0;
      done   <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state == FIX);
      case (state)
        IDLE: begin
          if (start) begin
            case (op_e)
              MD_MTHI: hi <= a;
              MD_MTLO: lo <= a;
              MD_MULT, MD_MULTU: begin
                acc    <= {32'd0, b_mag};
                opnd   <= a_mag;
                is_div <= 1'b0;
              end
              MD_DIV, MD_DIVU: begin
                acc    <= {32'd0, a_mag};
                opnd   <= b_mag;
                is_div <= 1'b1;
              end
              default: ;
            endcase
            sign_a <= a_neg;
            sign_b <= b_neg;
            iter   <= '0;
          end
        end
        RUN: begin
          acc  <= acc_nxt;
          iter <= iter + 5'd1;
        end
        FIX: begin
          if (is_div) begin
            // With a zero divisor the remainder ends as |a|, so the sign fix below restores a.
            lo <= (opnd == 32'd0) ? 32'hFFFF_FFFF :
                  ((sign_a ^ sign_b) ? neg32(acc[31:0]) : acc[31:0]);
            hi <= sign_a ? neg32(acc[63:32]) : acc[63:32];
          end else begin
            {hi, lo} <= (sign_a ^ sign_b) ? neg64(acc) : acc;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// Randomized + directed bench for mult_div_unit against a cycle-level arithmetic reference model.
module tb_mult_div_unit;
  import mips_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic        busy, done;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  bit chk_en = 1'b0;

  // Reference model state
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_left = 0;
  bit          m_done = 1'b0;

  mult_div_unit dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] ref_result(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint sx, sy, q, r;
    logic [63:0] p;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    p  = 64'd0;
    case (md_op_t'(o))
      MD_MULT:  p = 64'(sx * sy);
      MD_MULTU: p = {32'd0, x} * {32'd0, y};
      MD_DIVU:  p = (y == 0) ? {x, 32'hFFFF_FFFF} : {x % y, x / y};
      MD_DIV: begin
        if (y == 0) p = {x, 32'hFFFF_FFFF};
        else begin
          q = sx / sy;
          r = sx % sy;
          p = {r[31:0], q[31:0]};
        end
      end
      default: p = 64'd0;
    endcase
    return p;
  endfunction

  // Model: a mult/div result lands 33 edges after issue; MTHI/MTLO land at the issue edge.
  always @(posedge clk) begin
    if (reset) begin
      m_hi = 0; m_lo = 0; m_left = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (m_left > 0) begin
        m_left--;
        if (m_left == 0) begin
          m_hi = p_hi; m_lo = p_lo; m_done = 1;
        end
      end else if (start) begin
        case (md_op_t'(op))
          MD_MTHI: m_hi = a;
          MD_MTLO: m_lo = a;
          MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
            {p_hi, p_lo} = ref_result(op, a, b);
            m_left = 33;
          end
          default: ;
        endcase
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", {31'd0, busy}, {31'd0, (m_left > 0)});
      check("done", {31'd0, done}, {31'd0, m_done});
      check("hi", hi, m_hi);
      check("lo", lo, m_lo);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    start = 1'b1; op = o; a = x; b = y;
    tick();
    start = 1'b0; op = 3'($urandom_range(0, 6)); a = $urandom; b = $urandom;
  endtask

  // Waits for idle; while busy, optionally hammers start with random ops that must be ignored.
  task automatic wait_idle(input bit noisy);
    int n = 0;
    while (busy && n < 100) begin
      if (noisy) begin
        start = 1'($urandom_range(0, 1)); op = 3'($urandom_range(0, 6));
        a = $urandom; b = $urandom;
      end
      tick();
      n++;
    end
    start = 1'b0;
    if (busy) begin
      failures++;
      $display("FAIL wait_idle: busy still 1 after %0d cycles, expected 0", n);
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    tick();
    chk_en = 1'b1;
    tick(); tick();
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    reset = 1'b0;
    tick();

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_idle(1'b0);
    check("multu_hi", hi, 32'hFFFF_FFFE);
    check("multu_lo", lo, 32'h0000_0001);

    issue(MD_MULT, 32'hFFFF_FFFD, 32'd5); wait_idle(1'b0);
    check("mult_neg_hi", hi, 32'hFFFF_FFFF);
    check("mult_neg_lo", lo, 32'hFFFF_FFF1);
    issue(MD_MULT, 32'h8000_0000, 32'h8000_0000); wait_idle(1'b0);
    check("mult_min_hi", hi, 32'h4000_0000);
    check("mult_min_lo", lo, 32'h0);

    issue(MD_DIVU, 32'd100, 32'd7); wait_idle(1'b0);
    check("divu_lo", lo, 32'd14);
    check("divu_hi", hi, 32'd2);
    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2); wait_idle(1'b0);
    check("div_nn_lo", lo, 32'hFFFF_FFFD);
    check("div_nn_hi", hi, 32'hFFFF_FFFF);
    issue(MD_DIV, 32'd7, 32'hFFFF_FFFE); wait_idle(1'b0);
    check("div_pn_lo", lo, 32'hFFFF_FFFD);
    check("div_pn_hi", hi, 32'd1);

    issue(MD_DIV, 32'h1234_5678, 32'd0); wait_idle(1'b0);
    check("div0_lo", lo, 32'hFFFF_FFFF);
    check("div0_hi", hi, 32'h1234_5678);
    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle(1'b0);
    check("divovf_lo", lo, 32'h8000_0000);
    check("divovf_hi", hi, 32'd0);

    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    check("mthi_busy", {31'd0, busy}, 32'd0);
    issue(MD_MTLO, 32'hCAFE_F00D, 32'd0);
    check("mthi_hi", hi, 32'hDEAD_BEEF);
    check("mtlo_lo", lo, 32'hCAFE_F00D);

    issue(MD_DIVU, 32'd100, 32'd7);
    tick(); tick();
    issue(MD_MTHI, 32'd1, 32'd0);
    wait_idle(1'b0);
    check("mthi_ignored_hi", hi, 32'd2);

    issue(MD_MULTU, 32'd3, 32'd4);
    repeat (10) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_hi", hi, 32'd0);
    check("abort_lo", lo, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    tick();
    issue(MD_MULTU, 32'd3, 32'd4); wait_idle(1'b0);
    check("after_abort_lo", lo, 32'd12);
    check("after_abort_hi", hi, 32'd0);

    for (int i = 0; i < 80; i++) begin
      issue(3'($urandom_range(0, 6)), pick(), pick());
      wait_idle(1'b1);
      repeat ($urandom_range(0, 2)) tick();
    end

    tick(); tick();
    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
